// File: rtl/block_unpacker.sv
// block_unpacker: buffers 128-bit cipher blocks in a small FIFO and drains
// each block as four 32-bit words, most significant word (blk_in[0:31]) first.
// Optional feature: define BLOCK_UNPACKER_LAST_EN to add the word_last port,
// which flags the fourth word of every block.
// Blocks arriving while the FIFO is full are dropped and flagged on the
// sticky overflow output, unless the head block's last word leaves in the
// same cycle, which frees an entry just in time.
module block_unpacker #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [0:127]             blk_in,
    input  logic                     blk_valid,
    output logic [31:0]              word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
`ifdef BLOCK_UNPACKER_LAST_EN
    output logic                     word_last,
`endif
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [0:127]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    word_idx;
    logic [0:127]  head;
    logic          full;
    logic          xfer;
    logic          pop;
    logic          wr_en;
    logic          drop;

    assign head       = mem[rd_ptr];
    assign word_valid = (level != '0);
    assign full       = (level == FULL_LEVEL);
    assign xfer       = word_valid & word_ready;
    assign pop        = xfer & (word_idx == 2'd3);
    // A word-3 pop frees the head entry in the same edge, so a full FIFO can still take a block.
    assign wr_en      = blk_valid & (~full | pop);
    assign drop       = blk_valid & full & ~pop;

`ifdef BLOCK_UNPACKER_LAST_EN
    assign word_last  = word_valid & (word_idx == 2'd3);
`endif

    // Present the current word of the head block; idle output is zero so reset shows word_out=0.
    always_comb begin
        word_out = '0;
        if (word_valid) begin
            word_out = head[{word_idx, 5'b0} +: 32];
        end
    end

    // Block storage; no reset needed since occupancy is tracked by level and the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_ptr] <= blk_in;
        end
    end

    // Pointers, word index, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_idx <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (xfer) begin
                word_idx <= word_idx + 2'd1;
            end
            case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_block_unpacker.sv
// Self-checking bench for block_unpacker (DEPTH=4). A negedge monitor keeps a
// reference occupancy/overflow model and a queue of expected words; directed
// sequences exercise latency, backpressure, overflow, full-with-pop, reset
// mid-block and continuous streaming.
module tb_block_unpacker;

    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic [0:127] blk_in;
    logic         blk_valid;
    logic [31:0]  word_out;
    logic         word_valid;
    logic         word_ready;
    logic [2:0]   level;
    logic         overflow;
    logic         clr_ovf;
`ifdef BLOCK_UNPACKER_LAST_EN
    logic         word_last;
`endif

    block_unpacker #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .blk_in     (blk_in),
        .blk_valid  (blk_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .level      (level),
        .overflow   (overflow),
`ifdef BLOCK_UNPACKER_LAST_EN
        .word_last  (word_last),
`endif
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] blk;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic [31:0]  w2;
        logic [31:0]  w3;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] exp_w [4];
    logic [31:0] exp_q [$];

    int  checks   = 0;
    int  failures = 0;
    bit  mon_en   = 1'b0;

    int       m_level = 0;
    logic [1:0] m_idx = 2'd0;
    bit       m_ovf   = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i);
        blk_in   = vecs[i].blk;
        exp_w[0] = vecs[i].w0;
        exp_w[1] = vecs[i].w1;
        exp_w[2] = vecs[i].w2;
        exp_w[3] = vecs[i].w3;
    endtask

    task automatic send(input int i);
        load(i);
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
    endtask

    task automatic drain();
        word_ready = 1'b1;
        for (int c = 0; c < 80 && level != 0; c++) tick();
        chk("drain_level", level, 0);
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Reference model: check state every cycle, then advance it with the inputs of the coming edge.
    always @(negedge clk) begin
        bit pop;
        bit drop;
        logic [31:0] e;
        if (mon_en) begin
            chk("level", level, m_level);
            chk("word_valid", word_valid, m_level != 0);
            chk("overflow", overflow, m_ovf);
            if (m_level == 0) chk("word_out_idle", word_out, 0);
`ifdef BLOCK_UNPACKER_LAST_EN
            chk("word_last", word_last, (m_level != 0) && (m_idx == 2'd3));
`endif
            if (!rst_n) begin
                m_level = 0;
                m_idx   = 2'd0;
                m_ovf   = 1'b0;
                exp_q.delete();
            end else begin
                pop  = 1'b0;
                drop = 1'b0;
                if (m_level != 0 && word_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("word_out_unexpected", word_out, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_out", word_out, e);
                    end
                    if (m_idx == 2'd3) pop = 1'b1;
                    m_idx = m_idx + 2'd1;
                end
                if (blk_valid) begin
                    if (m_level < DEPTH || pop) begin
                        for (int k = 0; k < 4; k++) exp_q.push_back(exp_w[k]);
                        m_level++;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (pop) m_level--;
                if (drop) m_ovf = 1'b1;
                else if (clr_ovf) m_ovf = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{128'h00112233_44556677_8899aabb_ccddeeff,
                    32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        vecs[1] = '{128'hdeadbeef_01234567_89abcdef_cafef00d,
                    32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};
        vecs[2] = '{128'hffffffff_00000000_a5a5a5a5_5a5a5a5a,
                    32'hffffffff, 32'h00000000, 32'ha5a5a5a5, 32'h5a5a5a5a};
        vecs[3] = '{128'h80000000_00000001_7fffffff_fffffffe,
                    32'h80000000, 32'h00000001, 32'h7fffffff, 32'hfffffffe};
        vecs[4] = '{128'h13579bdf_2468ace0_0f0f0f0f_f0f0f0f0,
                    32'h13579bdf, 32'h2468ace0, 32'h0f0f0f0f, 32'hf0f0f0f0};

        rst_n      = 1'b0;
        blk_in     = '0;
        blk_valid  = 1'b0;
        word_ready = 1'b0;
        clr_ovf    = 1'b0;
        for (int k = 0; k < 4; k++) exp_w[k] = '0;
        tick();
        tick();
        mon_en = 1'b1;
        chk("reset_level", level, 0);
        chk("reset_word_valid", word_valid, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_word_out", word_out, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven single blocks: 1-cycle latency, word order, word_last on word 3.
        word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(i);
            for (int k = 0; k < 4; k++) begin
                chk("tbl_word_valid", word_valid, 1);
                chk("tbl_word", word_out, exp_w[k]);
`ifdef BLOCK_UNPACKER_LAST_EN
                chk("tbl_word_last", word_last, k == 3);
`endif
                tick();
            end
            chk("tbl_level_after", level, 0);
        end

        // Backpressure after word 1.
        send(0);
        tick();
        word_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_word", word_out, 32'h44556677);
            chk("bp_hold_valid", word_valid, 1);
            tick();
        end
        drain();

        // Overflow: five back-to-back blocks, consumer stalled.
        word_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load(i);
            blk_valid = 1'b1;
            tick();
        end
        blk_valid = 1'b0;
        chk("ovf_level_full", level, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head_word", word_out, 32'h00112233);
        drain();
        chk("ovf_flag_sticky", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full FIFO with head word 3 leaving as a new block arrives.
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(i);
        chk("fwp_level_full", level, 4);
        word_ready = 1'b1;
        repeat (3) tick();
        chk("fwp_head_word3", word_out, 32'hccddeeff);
        load(4);
        blk_valid = 1'b1;
        tick();
        blk_valid  = 1'b0;
        word_ready = 1'b0;
        chk("fwp_level_kept", level, 4);
        chk("fwp_no_overflow", overflow, 0);
        chk("fwp_next_head", word_out, 32'hdeadbeef);
        drain();

        // Reset after word 1, with blk_valid asserted during reset.
        send(1);
        tick();
        chk("rst_mid_word1", word_out, 32'h01234567);
        rst_n = 1'b0;
        load(3);
        blk_valid = 1'b1;
        tick();
        rst_n     = 1'b1;
        blk_valid = 1'b0;
        chk("rst_word_valid", word_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_word_out", word_out, 0);
        tick();
        chk("rst_still_empty", level, 0);
        send(2);
        chk("rst_fresh_word0", word_out, 32'hffffffff);
        drain();

        // Continuous streaming: one block every 4 cycles.
        word_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            load(n % 5);
            blk_valid = 1'b1;
            tick();
            blk_valid = 1'b0;
            for (int c = 0; c < 4; c++) begin
                chk("stream_valid", word_valid, 1);
                chk("stream_level_le1", level <= 1, 1);
                if (c < 3) tick();
            end
        end
        tick();
        chk("stream_no_overflow", overflow, 0);
        drain();

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_unpacker.md
BLOCK_UNPACKER -- requirements
Module: block_unpacker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the block FIFO depth in 128-bit entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit, the clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, the reset: synchronous, active-low.
REQ-004 SHALL have port blk_in, input, 128 bits [0:127], the cipher output block; bit 0 is the MSB of byte 0.
REQ-005 SHALL have port blk_valid, input, 1 bit, which qualifies blk_in for one cycle; it has no backpressure.
REQ-006 SHALL have port word_out, output, 32 bits [31:0], the output word.
REQ-007 SHALL have port word_valid, output, 1 bit, which is high when word_out holds a valid word.
REQ-008 SHALL have port word_ready, input, 1 bit, the consumer accept signal.
REQ-009 SHALL have port level, output, $clog2(DEPTH)+1 bits, the number of occupied FIFO entries, including a partially drained head.
REQ-010 SHALL have port overflow, output, 1 bit, a sticky flag for a dropped block.
REQ-011 SHALL have port clr_ovf, input, 1 bit, which clears overflow.
REQ-012 SHALL have port word_last, output, 1 bit, marking the final word of a block; it exists only under BLOCK_UNPACKER_LAST_EN.

Function
REQ-013 SHALL write blk_in into the FIFO tail on each cycle where blk_valid=1 and the write is permitted.
REQ-014 SHALL emit each block as four words in this order: word 0 = blk_in[0:31], word 1 = [32:63], word 2 = [64:95], word 3 = [96:127].
REQ-015 SHALL take a word as transferred on each cycle where word_valid=1 and word_ready=1; the 2-bit word index then increments, wrapping 3->0.
REQ-016 SHALL pop the head entry and decrement level when word 3 is transferred.
REQ-017 SHALL raise word_valid exactly whenever level != 0; word_out is driven from the head entry at the current word index.
REQ-018 SHALL have a latency of 1 cycle: a block written at edge t into an empty FIFO gives word_valid=1 with word 0 immediately after edge t.
REQ-019 SHALL hold word_out and word_valid stable while word_valid=1 and word_ready=0.
REQ-020 SHALL, on a write with level<DEPTH, accept the block.
REQ-021 SHALL, on a write with level=DEPTH and word 3 transferring in the same cycle, accept the block and leave level unchanged.
REQ-022 SHALL, on a write with level=DEPTH and no word-3 transfer, drop the block, leave FIFO contents and pointers unchanged, and set overflow=1 at the next edge.
REQ-023 SHALL, when a write and a pop occur together at level 1..DEPTH-1, leave level unchanged.
REQ-024 SHALL, when a write and the word-3 pop occur together at level=1, not break word flow: the new block's word 0 is presented on the next cycle.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH.
REQ-026 SHALL clear overflow on clr_ovf=1 and set it on a simultaneous drop; set wins.

Reset
REQ-027 SHALL, on rst_n=0 at a rising edge, flush the FIFO, zero both pointers and the word index, and force level=0, overflow=0, word_valid=0, word_last=0 and word_out=0.
REQ-028 SHALL discard a partially drained block if reset occurs mid-operation; no word of it is emitted after reset.
REQ-029 SHALL ignore blk_valid during reset.

Configuration
REQ-030 SHALL, with macro BLOCK_UNPACKER_LAST_EN defined, provide port word_last, which is 1 exactly when word_valid=1 and the word index is 3.
REQ-031 SHALL, with BLOCK_UNPACKER_LAST_EN undefined, omit port word_last and its logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover the single block case: blk_in=00112233_44556677_8899aabb_ccddeeff pulsed for one cycle with word_ready=1 -> words 00112233, 44556677, 8899aabb, ccddeeff on 4 consecutive cycles starting 1 cycle later, word_last on the 4th, then level=0.
REQ-033 SHALL cover backpressure: word_ready=0 for 5 cycles after word 1 -> word_out held at 44556677 and word_valid stays 1; the remaining words follow once word_ready=1.
REQ-034 SHALL cover overflow with DEPTH=4: 5 blocks on consecutive cycles with word_ready=0 -> level=4, overflow=1, and 16 words emitted afterwards from blocks 1-4 only; clr_ovf=1 for one cycle -> overflow=0.
REQ-035 SHALL cover the full-with-pop case: level=4 and the head at word 3 transferring while a new block arrives -> block accepted, overflow stays 0, level stays 4.
REQ-036 SHALL cover reset mid-operation: rst_n=0 for one cycle after word 1 of a block -> word_valid=0 and level=0 on the next cycle, and a fresh block afterwards starts at word 0.
REQ-037 SHALL cover continuous streaming: a blk_valid pulse every 4 cycles with word_ready=1 -> word_valid held high, level never exceeds 1, and no overflow.
